i2s_rx: RTL and testbench
=========================

# i2s_rx

Serial audio receiver for the FM transmitter datapath. It deserialises a two-slot, MSB-first I2S-style stream clocked by the bit clock itself and presents both channel words in parallel. It emits a one-cycle `data_updated` strobe each time a complete frame has been latched. Downstream DDS/FM logic consumes `first_channel`/`second_channel` on that strobe.

## Interface
- `CH_WIDTH`, default 32: channel word width and nominal slot length in bits.
- `i2s_ck`  in  1  bit clock and the only clock. All logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i2s_ws`  in  1  word select. 1 = first-channel slot, 0 = second-channel slot.
- `i2s_sd`  in  1  serial data, MSB first. Changes on falling edges; sampled on rising edges.
- `first_channel`  out  CH_WIDTH  last latched first-channel (WS=1) word.
- `second_channel`  out  CH_WIDTH  last latched second-channel (WS=0) word.
- `data_updated`  out  1  one-cycle pulse when both outputs were refreshed.

## Operation
- Every rising edge samples `i2s_ws` and `i2s_sd`. `ws_q` holds the previous sampled WS.
- **Slot boundary:** the edge where sampled WS ≠ `ws_q`.
- **Bit placement:** a bit counter (0..CH_WIDTH, saturating) places each bit at position CH_WIDTH-1-count of the slot shift register.
  - At a slot boundary the counter restarts. The bit sampled on that edge is written to the MSB of the new slot (left-justified, no delay) and the register's other bits are cleared.
  - Slot shorter than CH_WIDTH: missing LSBs are 0.
  - Slot longer than CH_WIDTH: bits beyond CH_WIDTH are ignored.
- **1→0 boundary:** the completed slot word is copied into an internal first-channel hold register.
- **0→1 boundary (frame end):** if `armed`, then on the same edge:
  - `first_channel` ← hold register;
  - `second_channel` ← completed slot word;
  - `data_updated` ← 1.
  - Both outputs always update together; never one without the other.
- **Arming:** `armed` is cleared by reset. It is set by the first 0→1 boundary after reset; that arming boundary produces no pulse. The frame that starts at the arming boundary is the first one reported.
- **Other edges:** `data_updated` ← 0; outputs hold their value.
- **Reset:** has priority over everything. It clears `first_channel`, `second_channel`, `data_updated`, the hold register, the shift register, the counter and `armed`. `ws_q` ← 0.
- A reset mid-frame discards the partial frame. The next 0→1 boundary re-arms.

## Timing
- **Latency:** outputs and `data_updated` change on the rising edge that samples the first WS=1 bit of the next frame. The LSB of the second slot was captured one edge earlier.
- **Strobe width:** `data_updated` is high for exactly one `i2s_ck` cycle per frame. The outputs stay stable until the next frame end.
- **Reset values:** all outputs 0.
- **Frame rate:** one pulse every 2·CH_WIDTH cycles at nominal framing. No minimum slot length is required; a 1-bit slot is legal.

## Configuration
- `I2S_RX_PHILIPS_DELAY_EN` undefined: left-justified framing as described above.
  - The MSB is sampled on the same edge as the WS change.
- `I2S_RX_PHILIPS_DELAY_EN` defined: standard Philips framing, with the MSB one bit clock after the WS change.
  - Slot boundaries and all capture logic use WS delayed by one extra register stage.
  - Each slot's LSB is the bit sampled on the first edge of the opposite WS level.
  - Latency grows by one cycle; everything else is unchanged.

## Structure
- **Package `i2s_pkg`:**
  - `CH_WIDTH_DEFAULT` = 32;
  - counter width `$clog2(CH_WIDTH+1)`;
  - typedef for the channel word.
- **Sub-module `i2s_slot_shift`:** one instance containing the bit counter, MSB-first placement and boundary restart, with output "slot word complete".
- The top level holds the WS edge detect, hold register, arming and output registers.

## Test plan
- **Reset:** hold `rst` for 3 cycles with toggling inputs → all outputs 0, no `data_updated`.
- **Repeated frames:** WS 0 idle, then four frames of 0x55555555 / 0xAAAAAAAA → four pulses, each showing `first_channel`=0x55555555 and `second_channel`=0xAAAAAAAA, each 1 cycle wide, 64 cycles apart.
- **Changing data:** 0xDEADBEEF/0xCAFEBABE, then 0xF0F0F0F0/0x0F0F0F0F, then WS→1 → pulses show those exact pairs; the final pair is latched only by the trailing WS rise.
- **Non-nominal slot lengths:**
  - 16-bit first slot 0xABCD → `first_channel`=0xABCD0000.
  - 40-bit first slot → the first 32 bits received are kept.
- **Mid-frame reset:** assert `rst` in the middle of the second slot → outputs cleared. The next WS rise arms without a pulse; the following frame is reported correctly.
- **Philips delay (`I2S_RX_PHILIPS_DELAY_EN` defined):** stimulus with a one-bit delay, 0x12345678/0x9ABCDEF0 → the same values are reported, with the pulse one cycle later than in left-justified mode.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared definitions for the I2S receiver.
//   CH_WIDTH_DEFAULT : default channel word width / nominal slot length (bits)
//   CNT_W_DEFAULT    : bit counter width for the default word width
//   ch_word_t        : channel word type at the default width
//   cnt_width()      : bit counter width for a given word width (counts 0..CH_WIDTH)
package i2s_pkg;

  localparam int CH_WIDTH_DEFAULT = 32;

  function automatic int cnt_width(input int ch_width);
    return $clog2(ch_width + 1);
  endfunction

  localparam int CNT_W_DEFAULT = $clog2(CH_WIDTH_DEFAULT + 1);

  typedef logic [CH_WIDTH_DEFAULT-1:0] ch_word_t;

endpackage

// File: rtl/i2s_slot_shift.sv
// i2s_slot_shift: MSB-first slot deserialiser.
// A saturating bit counter (0..CH_WIDTH) places each sampled bit at position
// CH_WIDTH-1-count. On a slot boundary the bit sampled on that edge becomes
// the MSB of the new slot and every other bit is cleared, so short slots
// leave zero LSBs and bits beyond CH_WIDTH are dropped.
// Ports:
//   clk           in   bit clock (rising edge)
//   rst           in   synchronous active-high reset
//   boundary      in   WS changed on this edge (start of a new slot)
//   sd            in   serial data bit sampled on this edge
//   slot_complete out  slot register; at a boundary it holds the completed word
module i2s_slot_shift
  import i2s_pkg::*;
#(
  parameter int CH_WIDTH = CH_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                boundary,
  input  logic                sd,
  output logic [CH_WIDTH-1:0] slot_complete
);

  localparam int CNT_W = cnt_width(CH_WIDTH);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(CH_WIDTH);
  localparam logic [CNT_W-1:0]    POS_TOP = CNT_W'(CH_WIDTH - 1);
  localparam logic [CH_WIDTH-1:0] LSB_ONE = CH_WIDTH'(1);

  logic [CNT_W-1:0]    cnt;
  logic [CH_WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (boundary) begin
      sr  <= sd ? (LSB_ONE << POS_TOP) : '0;
      cnt <= CNT_W'(1);
    end else if (cnt != CNT_MAX) begin
      // register was cleared at the boundary, so OR-ing in the bit suffices
      if (sd) sr <= sr | (LSB_ONE << (POS_TOP - cnt));
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign slot_complete = sr;

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: two-slot MSB-first serial audio receiver clocked by the bit clock.
// Presents both channel words in parallel with a one-cycle data_updated
// strobe per complete frame (WS=1 slot followed by WS=0 slot).
// Optional feature macro: I2S_RX_PHILIPS_DELAY_EN
//   undefined : left-justified framing, MSB sampled on the WS-change edge
//   defined   : Philips framing, WS delayed one extra stage (MSB one bit later)
// Ports:
//   i2s_ck         in   bit clock, the only clock (rising edge)
//   rst            in   synchronous active-high reset
//   i2s_ws         in   word select, 1 = first-channel slot, 0 = second
//   i2s_sd         in   serial data, MSB first
//   first_channel  out  last latched first-channel word
//   second_channel out  last latched second-channel word
//   data_updated   out  one-cycle pulse when both outputs were refreshed
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int CH_WIDTH = CH_WIDTH_DEFAULT
) (
  input  logic                i2s_ck,
  input  logic                rst,
  input  logic                i2s_ws,
  input  logic                i2s_sd,
  output logic [CH_WIDTH-1:0] first_channel,
  output logic [CH_WIDTH-1:0] second_channel,
  output logic                data_updated
);

  logic ws_q;
  logic ws_cur;
  logic ws_prev;

`ifdef I2S_RX_PHILIPS_DELAY_EN
  logic ws_qq;

  always_ff @(posedge i2s_ck) begin
    if (rst) begin
      ws_q  <= 1'b0;
      ws_qq <= 1'b0;
    end else begin
      ws_q  <= i2s_ws;
      ws_qq <= ws_q;
    end
  end

  // one bit clock of extra WS delay lines the boundary up with the MSB
  assign ws_cur  = ws_q;
  assign ws_prev = ws_qq;
`else
  always_ff @(posedge i2s_ck) begin
    if (rst) ws_q <= 1'b0;
    else     ws_q <= i2s_ws;
  end

  assign ws_cur  = i2s_ws;
  assign ws_prev = ws_q;
`endif

  logic                boundary;
  logic                ws_rise;
  logic                ws_fall;
  logic [CH_WIDTH-1:0] slot_complete;
  logic [CH_WIDTH-1:0] first_hold;
  logic                armed;

  assign boundary = ws_cur ^ ws_prev;
  assign ws_rise  = ws_cur & ~ws_prev;
  assign ws_fall  = ~ws_cur & ws_prev;

  i2s_slot_shift #(
    .CH_WIDTH(CH_WIDTH)
  ) u_slot_shift (
    .clk          (i2s_ck),
    .rst          (rst),
    .boundary     (boundary),
    .sd           (i2s_sd),
    .slot_complete(slot_complete)
  );

  // The first 0->1 boundary after reset only arms: the slot before it is a
  // partial or idle one, so nothing is reported for it.
  always_ff @(posedge i2s_ck) begin
    if (rst) begin
      first_hold     <= '0;
      first_channel  <= '0;
      second_channel <= '0;
      data_updated   <= 1'b0;
      armed          <= 1'b0;
    end else begin
      data_updated <= 1'b0;
      if (ws_fall) first_hold <= slot_complete;
      if (ws_rise) begin
        if (armed) begin
          first_channel  <= first_hold;
          second_channel <= slot_complete;
          data_updated   <= 1'b1;
        end
        armed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: scoreboard bench for i2s_rx. The driver pushes the expected
// channel pair and strobe cycle whenever it drives the WS rise that ends a
// reported frame; an independent monitor pops and compares on each strobe.
// Define I2S_RX_PHILIPS_DELAY_EN for both bench and RTL to cover Philips mode.
module tb_i2s_rx;

  localparam int CW = 32;
`ifdef I2S_RX_PHILIPS_DELAY_EN
  localparam bit PHIL = 1'b1;
  localparam int LAT  = 2;
`else
  localparam bit PHIL = 1'b0;
  localparam int LAT  = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ws  = 1'b0;
  logic          sd  = 1'b0;
  logic [CW-1:0] fc;
  logic [CW-1:0] sc;
  logic          du;

  i2s_rx #(
    .CH_WIDTH(CW)
  ) dut (
    .i2s_ck        (clk),
    .rst           (rst),
    .i2s_ws        (ws),
    .i2s_sd        (sd),
    .first_channel (fc),
    .second_channel(sc),
    .data_updated  (du)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] f;
    logic [31:0] s;
    int          at;
  } exp_t;

  exp_t expq[$];
  exp_t e_m;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor
  logic du_prev = 1'b0;
  always @(negedge clk) begin
    if (du === 1'b1) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: data_updated=1 at cycle %0d, required 0", cyc);
      end else begin
        e_m = expq.pop_front();
        check("first_channel", fc, e_m.f);
        check("second_channel", sc, e_m.s);
        check("pulse_cycle", 32'(cyc), 32'(e_m.at));
      end
      check("strobe_one_cycle", {31'b0, du_prev}, 32'h0);
    end
    du_prev <= du;
  end

  // driver state
  logic        last_ws = 1'b0;
  logic        prev_d  = 1'b0;
  logic        pend    = 1'b0;
  logic [31:0] pend_f  = '0;
  logic [31:0] pend_s  = '0;

  task automatic drive_bit(input logic w, input logic d);
    @(negedge clk);
    if (w && !last_ws && pend) begin
      expq.push_back('{pend_f, pend_s, cyc + LAT});
      pend = 1'b0;
    end
    last_ws = w;
    ws      = w;
    sd      = PHIL ? prev_d : d;  // Philips: data lags WS by one bit
    prev_d  = d;
  endtask

  task automatic send_slot(input logic w, input logic [63:0] bits, input int n);
    for (int i = 0; i < n; i++) drive_bit(w, bits[63-i]);
  endtask

  task automatic frame_n(input logic [63:0] b1, input int n1, input logic [63:0] b0,
                         input int n0, input logic [31:0] ef, input logic [31:0] es);
    send_slot(1'b1, b1, n1);
    send_slot(1'b0, b0, n0);
    pend_f = ef;
    pend_s = es;
    pend   = 1'b1;
  endtask

  task automatic frame(input logic [31:0] a, input logic [31:0] b);
    frame_n({a, 32'h0}, 32, {b, 32'h0}, 32, a, b);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_first"}, fc, 32'h0);
    check({tag, "_second"}, sc, 32'h0);
    check({tag, "_strobe"}, {31'b0, du}, 32'h0);
  endtask

  initial begin
    // reset held for 3 cycles with toggling inputs, ending with WS low
    for (int i = 0; i < 3; i++) drive_bit(i == 1, (i % 2) == 0);
    check_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0);
    check_zero("idle");

    // repeated frames; the first rise only arms
    for (int i = 0; i < 4; i++) frame(32'h55555555, 32'hAAAAAAAA);

    // changing data
    frame(32'hDEADBEEF, 32'hCAFEBABE);
    frame(32'hF0F0F0F0, 32'h0F0F0F0F);

    // non-nominal slot lengths: 16-bit and 40-bit first slots
    frame_n({16'hABCD, 48'h0}, 16, {32'h11223344, 32'h0}, 32, 32'hABCD0000, 32'h11223344);
    frame_n({32'h13579BDF, 8'hFF, 24'h0}, 40, {32'h55AA55AA, 32'h0}, 32,
            32'h13579BDF, 32'h55AA55AA);

    frame(32'h12345678, 32'h9ABCDEF0);

    // mid-frame reset halfway through the second slot
    send_slot(1'b1, {32'hA5A5A5A5, 32'h0}, 32);
    send_slot(1'b0, {32'h3C3C3C3C, 32'h0}, 16);
    rst = 1'b1;
    pend = 1'b0;
    drive_bit(1'b0, 1'b0);
    check_zero("midreset");
    drive_bit(1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b0);
    check_zero("after_reset");

    frame(32'h01234567, 32'h89ABCDEF);  // arming frame, reported at next rise
    frame(32'h0BADF00D, 32'h600DCAFE);
    send_slot(1'b1, 64'h0, 4);          // trailing WS rise latches the last pair
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);

    check("pending_pulses", 32'(expq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
